pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised elastic pipeline stage register, the general-purpose successor to the fixed per-stage IF/ID/EX/MEM/WB registers. It carries a control bundle and a data bundle between two pipeline stages using a valid/ready handshake. It supports downstream back-pressure without dropping beats, a flush that inserts bubbles, and a saturating stall counter. Every stage boundary of the MIPS core instantiates it with its own widths.

## Interface
- CTRL_W, 8: width of control bundle (RegWrite, MemToReg, ...); zeroed whenever the stage holds a bubble
- DATA_W, 101: width of data bundle (ALU result, PC, read data, RegDest, ...); never zeroed by flush
- CNT_W, 16: width of stall counter
- Clock  in  1  sole clock, all state on rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- Flush  in  1  synchronous; discards all held beats
- In_Valid  in  1  upstream beat present
- In_Ready  out  1  stage can accept a beat
- In_Ctrl  in  CTRL_W  upstream control
- In_Data  in  DATA_W  upstream data
- Out_Valid  out  1  beat present for downstream
- Out_Ready  in  1  downstream consumes beat
- Out_Ctrl  out  CTRL_W  control of head beat; all-zero when Out_Valid=0
- Out_Data  out  DATA_W  data of head beat
- StallCount  out  CNT_W  cycles spent back-pressured

## Operation
- The stage has two slots: main M (drives outputs) and skid S. Each slot has a valid bit, a ctrl field and a data field.
- accept = In_Valid & In_Ready. emit = Out_Valid & Out_Ready.
- Out_Valid = M.valid. Out_Data = M.data. Out_Ctrl = M.valid ? M.ctrl : 0.
- In_Ready = !S.valid. It is a registered function of state only, with no combinational path from Out_Ready.
- States:
  - EMPTY: M and S invalid.
  - ONE: M valid, S invalid.
  - FULL: M and S valid.
- Transitions:
  - EMPTY: accept → ONE, M<=in.
  - ONE: accept&emit → ONE, M<=in. accept&!emit → FULL, S<=in. emit&!accept → EMPTY. Neither → hold.
  - FULL: In_Ready=0. emit → ONE, M<=S. Otherwise hold.
- Beats leave in arrival order. No beat is duplicated or lost, except on Flush.
- Flush has priority over every transition:
  - Next state is EMPTY and both ctrl fields are cleared to 0.
  - Data fields hold their values.
  - A beat accepted in the same cycle is discarded, and upstream treats it as consumed.
  - A beat emitted in the same cycle counts as delivered.
- StallCount increments by 1 on each edge where Out_Valid & !Out_Ready. It saturates at 2^CNT_W-1, is unaffected by Flush, and clears only on Reset.

## Timing
- Reset values: Out_Valid=0, Out_Ctrl=0, Out_Data=0, StallCount=0, In_Ready=1, S.valid=0. Reset asserted mid-transfer discards all beats at once.
- First accept is possible on the first edge after Reset deasserts.
- Latency: a beat accepted at edge N appears on Out_* after edge N (one cycle).
- Throughput: one beat per cycle while Out_Ready=1.
- After Out_Ready falls, the stage absorbs exactly one more beat; In_Ready drops one cycle after the stall begins.
- Once Out_Ready rises, In_Ready returns to 1 the cycle after the first emit.
- Flush at edge N: Out_Valid=0 and In_Ready=1 after edge N.

## Configuration
- Macro: PIPE_STAGE_SKID_EN.
- Defined: the two-slot behaviour above applies, and In_Ready is registered.
- Undefined:
  - No S slot; the FULL state does not exist.
  - In_Ready = !M.valid | Out_Ready, combinational from Out_Ready.
  - ONE with accept&!emit cannot occur.
  - Flush and StallCount behave identically to the defined case.
- Latency and throughput are unchanged in both builds.

## Test plan
- Reset mid-stream, with Out_Valid=1 and StallCount=5 → all outputs go to their reset values asynchronously, before the next edge. In_Ready=1.
- Stream ctrl 0x01..0x04 (data 1..4), one beat per cycle, Out_Ready=1 → Out_Ctrl 0x01..0x04 appear on consecutive cycles, one cycle after each accept.
- Out_Ready=0 while sending 0x11 then 0x22 then holding 0x33:
  - 0x11 and 0x22 are accepted and In_Ready drops to 0.
  - StallCount increments each stalled cycle.
  - With Out_Ready=1, 0x11, 0x22 and 0x33 emerge in order with no gap.
- Flush in the FULL state, with In_Valid=1 and ctrl 0x44 → after the edge Out_Valid=0, Out_Ctrl=0, In_Ready=1. 0x44 is never emitted.
- Hold Out_Valid=1 with Out_Ready=0 for 2^CNT_W+3 cycles (CNT_W=4) → StallCount reaches 15 and stays at 15.
- Rerun scenario 3 with PIPE_STAGE_SKID_EN undefined → In_Ready tracks Out_Ready in the same cycle. Only 0x11 is buffered, and order is preserved.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: valid/ready handshake with back-pressure, flush and a saturating stall counter.
// Build option PIPE_STAGE_SKID_EN adds a skid slot so In_Ready is registered (no Out_Ready -> In_Ready path).
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 101,
  parameter int CNT_W  = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data,
  output logic [CNT_W-1:0]  StallCount
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [CTRL_W-1:0] m_ctrl_reg, m_ctrl_next;
  logic [DATA_W-1:0] m_data_reg, m_data_next;
`ifdef PIPE_STAGE_SKID_EN
  logic [CTRL_W-1:0] s_ctrl_reg, s_ctrl_next;
  logic [DATA_W-1:0] s_data_reg, s_data_next;
`endif
  logic [CNT_W-1:0]  stall_cnt_reg;

  logic m_valid;
  logic accept;
  logic emit;

  assign m_valid = (state_reg != EMPTY);

`ifdef PIPE_STAGE_SKID_EN
  assign In_Ready = (state_reg != FULL);
`else
  assign In_Ready = !m_valid | Out_Ready;
`endif

  assign accept     = In_Valid & In_Ready;
  assign emit       = m_valid & Out_Ready;
  assign Out_Valid  = m_valid;
  assign Out_Ctrl   = m_valid ? m_ctrl_reg : '0;
  assign Out_Data   = m_data_reg;
  assign StallCount = stall_cnt_reg;

  always_comb begin
    state_next  = state_reg;
    m_ctrl_next = m_ctrl_reg;
    m_data_next = m_data_reg;
`ifdef PIPE_STAGE_SKID_EN
    s_ctrl_next = s_ctrl_reg;
    s_data_next = s_data_reg;
`endif
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next  = ONE;
          m_ctrl_next = In_Ctrl;
          m_data_next = In_Data;
        end
      end
      ONE: begin
        if (accept && emit) begin
          m_ctrl_next = In_Ctrl;
          m_data_next = In_Data;
        end else if (emit) begin
          state_next = EMPTY;
`ifdef PIPE_STAGE_SKID_EN
        end else if (accept) begin
          state_next  = FULL;
          s_ctrl_next = In_Ctrl;
          s_data_next = In_Data;
`endif
        end
      end
`ifdef PIPE_STAGE_SKID_EN
      FULL: begin
        if (emit) begin
          state_next  = ONE;
          m_ctrl_next = s_ctrl_reg;
          m_data_next = s_data_reg;
        end
      end
`endif
      default: state_next = EMPTY;
    endcase

    // Flush drops every held beat; data payloads are left untouched on purpose.
    if (Flush) begin
      state_next  = EMPTY;
      m_ctrl_next = '0;
      m_data_next = m_data_reg;
`ifdef PIPE_STAGE_SKID_EN
      s_ctrl_next = '0;
      s_data_next = s_data_reg;
`endif
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg  <= EMPTY;
      m_ctrl_reg <= '0;
      m_data_reg <= '0;
`ifdef PIPE_STAGE_SKID_EN
      s_ctrl_reg <= '0;
      s_data_reg <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      m_ctrl_reg <= m_ctrl_next;
      m_data_reg <= m_data_next;
`ifdef PIPE_STAGE_SKID_EN
      s_ctrl_reg <= s_ctrl_next;
      s_data_reg <= s_data_next;
`endif
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stall_cnt_reg <= '0;
    end else if (m_valid && !Out_Ready && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based reference model plus directed scenarios.
// Works with or without PIPE_STAGE_SKID_EN defined; the model picks the matching stage capacity.
module tb_pipe_stage_reg;
  localparam int CTRL_W  = 8;
  localparam int DATA_W  = 101;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic              Flush = 1'b0;
  logic              In_Valid = 1'b0;
  logic              In_Ready;
  logic [CTRL_W-1:0] In_Ctrl = '0;
  logic [DATA_W-1:0] In_Data = '0;
  logic              Out_Valid;
  logic              Out_Ready = 1'b0;
  logic [CTRL_W-1:0] Out_Ctrl;
  logic [DATA_W-1:0] Out_Data;
  logic [CNT_W-1:0]  StallCount;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset(Reset), .Flush(Flush),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Ctrl(In_Ctrl), .In_Data(In_Data),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Ctrl(Out_Ctrl), .Out_Data(Out_Data),
    .StallCount(StallCount)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } beat_t;
  typedef struct {
    int                cyc;
    logic [CTRL_W-1:0] c;
  } emit_t;

  beat_t q[$];
  emit_t emits[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    m_cnt = 0;
  int    idx;
  bit    last_accept = 1'b0;
  bit    acc, emt;
  logic [CTRL_W-1:0] tx [3];

  function automatic logic [DATA_W-1:0] mk_data(input logic [CTRL_W-1:0] c);
    return {c, 85'h0, c};
  endfunction

  function automatic bit exp_in_ready();
`ifdef PIPE_STAGE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || (Out_Ready == 1'b1);
`endif
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic ordy, input logic fl);
    In_Valid  = v;
    In_Ctrl   = c;
    In_Data   = mk_data(c);
    Out_Ready = ordy;
    Flush     = fl;
  endtask

  // Reference model: the stage is a FIFO of capacity 2 (skid) or 1, emptied by Flush or Reset.
  initial forever begin
    @(posedge Clock or posedge Reset);
    if (Reset) begin
      q.delete();
      m_cnt = 0;
      last_accept = 1'b0;
    end else begin
      cyc++;
      acc = In_Valid && exp_in_ready();
      emt = (q.size() > 0) && Out_Ready;
      if ((q.size() > 0) && !Out_Ready && (m_cnt < CNT_MAX)) m_cnt++;
      if (Flush) begin
        q.delete();
      end else begin
        if (emt) q.delete(0);
        if (acc) q.push_back('{In_Ctrl, In_Data});
      end
      last_accept = acc;
    end
  end

  // Per-cycle comparison against the model, plus a log of beats the DUT delivers.
  initial forever begin
    @(negedge Clock);
    chk("out_valid", 128'(Out_Valid), 128'(q.size() > 0));
    chk("in_ready", 128'(In_Ready), 128'(exp_in_ready()));
    chk("stall_count", 128'(StallCount), 128'(m_cnt));
    if (q.size() > 0) begin
      chk("out_ctrl", 128'(Out_Ctrl), 128'(q[0].c));
      chk("out_data", 128'(Out_Data), 128'(q[0].d));
    end else begin
      chk("out_ctrl_idle", 128'(Out_Ctrl), 128'(0));
    end
    if (!Reset && Out_Valid && Out_Ready) emits.push_back('{cyc, Out_Ctrl});
  end

  initial begin
    tx[0] = 8'h11;
    tx[1] = 8'h22;
    tx[2] = 8'h33;

    // Power-on reset
    repeat (2) @(posedge Clock);
    #3;
    chk("rst_out_valid", 128'(Out_Valid), 128'(0));
    chk("rst_in_ready", 128'(In_Ready), 128'(1));
    chk("rst_stall", 128'(StallCount), 128'(0));
    chk("rst_out_data", 128'(Out_Data), 128'(0));
    @(posedge Clock);
    #2;
    Reset = 1'b0;

    // Streaming, one beat per cycle
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, CTRL_W'(i), 1'b1, 1'b0);
      tick();
      #1;
      chk("stream_out_valid", 128'(Out_Valid), 128'(1));
      chk("stream_out_ctrl", 128'(Out_Ctrl), 128'(i));
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    #1;
    chk("stream_drained", 128'(Out_Valid), 128'(0));

    // Back-pressure: 0x11, 0x22, 0x33 against a stalled consumer
    emits.delete();
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      drive(idx < 3, (idx < 3) ? tx[idx] : 8'h00, c >= 3, 1'b0);
      if (c == 3) begin
        #1;
`ifdef PIPE_STAGE_SKID_EN
        chk("bp_in_ready_registered", 128'(In_Ready), 128'(0));
`else
        chk("bp_in_ready_tracks", 128'(In_Ready), 128'(1));
`endif
      end
      tick();
      if (last_accept) idx++;
      if (c == 2) begin
        #1;
`ifdef PIPE_STAGE_SKID_EN
        chk("bp_accepted", 128'(idx), 128'(2));
`else
        chk("bp_accepted", 128'(idx), 128'(1));
`endif
        chk("bp_in_ready_low", 128'(In_Ready), 128'(0));
        chk("bp_head", 128'(Out_Ctrl), 128'(8'h11));
        chk("bp_stall", 128'(StallCount), 128'(2));
      end
    end
    chk("bp_emit_count", 128'(emits.size()), 128'(3));
    if (emits.size() >= 3) begin
      chk("bp_order0", 128'(emits[0].c), 128'(8'h11));
      chk("bp_order1", 128'(emits[1].c), 128'(8'h22));
      chk("bp_order2", 128'(emits[2].c), 128'(8'h33));
      chk("bp_gap01", 128'(emits[1].cyc - emits[0].cyc), 128'(1));
      chk("bp_gap12", 128'(emits[2].cyc - emits[1].cyc), 128'(1));
    end

    // Flush while holding beats, with 0x44 offered
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h66, 1'b0, 1'b0);
    tick();
    emits.delete();
    drive(1'b1, 8'h44, 1'b0, 1'b1);
    tick();
    #1;
    chk("flush_out_valid", 128'(Out_Valid), 128'(0));
    chk("flush_out_ctrl", 128'(Out_Ctrl), 128'(0));
    chk("flush_in_ready", 128'(In_Ready), 128'(1));
    chk("flush_stall_kept", 128'(StallCount), 128'(4));
    drive(1'b1, 8'h77, 1'b1, 1'b1);
    tick();
    #1;
    chk("flush_accept_dropped", 128'(Out_Valid), 128'(0));
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) tick();
    chk("flush_nothing_emitted", 128'(emits.size()), 128'(0));

    // Asynchronous reset in the middle of a stall
    drive(1'b1, 8'h88, 1'b0, 1'b0);
    tick();
    tick();
    #1;
    chk("pre_rst_out_valid", 128'(Out_Valid), 128'(1));
    chk("pre_rst_stall", 128'(StallCount), 128'(5));
    Reset = 1'b1;
    #1;
    chk("arst_out_valid", 128'(Out_Valid), 128'(0));
    chk("arst_out_ctrl", 128'(Out_Ctrl), 128'(0));
    chk("arst_out_data", 128'(Out_Data), 128'(0));
    chk("arst_stall", 128'(StallCount), 128'(0));
    chk("arst_in_ready", 128'(In_Ready), 128'(1));
    tick();
    Reset = 1'b0;
    drive(1'b1, 8'h99, 1'b0, 1'b0);
    tick();
    #1;
    chk("first_accept_valid", 128'(Out_Valid), 128'(1));
    chk("first_accept_ctrl", 128'(Out_Ctrl), 128'(8'h99));
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Stall counter saturation
    repeat (15) tick();
    chk("stall_reach_max", 128'(StallCount), 128'(15));
    repeat (4) tick();
    chk("stall_saturated", 128'(StallCount), 128'(15));
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    #1;
    chk("final_drain", 128'(Out_Valid), 128'(0));
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
